// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IE_BIT     = 0;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational interrupt/exception request arbitration and ExcCode select.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic       o_req,
  output logic [4:0] o_exc_sel
);

  assign o_int_req = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
  assign o_exc_req = (i_exc_code != 5'd0) & ~i_exl;
  assign o_req     = o_int_req | o_exc_req;
  // Interrupt wins over a simultaneous synchronous exception.
  assign o_exc_sel = o_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt/exception controller: SR, Cause, EPC, PRId and request to pipeline.
// Optional BadVAddr (reg 8) enabled by defining CP0_BADVADDR_EN.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID      = 32'h0000_5200,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [4:0]  RdAddr,
  input  logic [4:0]  WrAddr,
  input  logic [31:0] WrData,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [31:0] VAddr,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] ExcEntry,
  output logic [31:0] EPCOut,
  output logic [31:0] RdData
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [4:0]  w_exc_sel;
  logic [31:0] w_victim;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_badvaddr;

  cp0_req_arb u_arb (
    .i_hw_int   (HWInt),
    .i_im       (r_im),
    .i_ie       (r_ie),
    .i_exl      (r_exl),
    .i_exc_code (ExcCodeIn),
    .o_int_req  (w_int_req),
    .o_exc_req  (w_exc_req),
    .o_req      (w_req),
    .o_exc_sel  (w_exc_sel)
  );

  // Delay-slot victims restart at the branch.
  assign w_victim = BDIn ? (VPC - 32'd4) : VPC;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl      <= 1'b1;
        r_bd       <= BDIn;
        r_epc      <= {w_victim[31:2], 2'b00};
        r_exc_code <= w_exc_sel;
      end else begin
        if (WE && WrAddr == REG_SR) begin
          r_im  <= WrData[SR_IM_LSB +: 6];
          r_exl <= WrData[SR_EXL_BIT];
          r_ie  <= WrData[SR_IE_BIT];
        end
        if (WE && WrAddr == REG_EPC)
          r_epc <= {WrData[31:2], 2'b00};
        // Later assignment: eret clears EXL after any same-cycle SR write.
        if (EXLClr)
          r_exl <= 1'b0;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] r_badvaddr;

  always_ff @(posedge CLK_I) begin
    if (RST_I)
      r_badvaddr <= '0;
    else if (w_req && !w_int_req && is_addr_err(ExcCodeIn))
      r_badvaddr <= VAddr;
  end

  assign w_badvaddr = r_badvaddr;
`else
  logic w_unused_vaddr;
  assign w_unused_vaddr = ^VAddr;
  assign w_badvaddr     = '0;
`endif

  always_comb begin
    w_sr                          = '0;
    w_sr[SR_IM_LSB +: 6]          = r_im;
    w_sr[SR_EXL_BIT]              = r_exl;
    w_sr[SR_IE_BIT]               = r_ie;
    w_cause                       = '0;
    w_cause[CAUSE_BD_BIT]         = r_bd;
    w_cause[CAUSE_IP_LSB +: 6]    = r_ip;
    w_cause[CAUSE_EXC_LSB +: 5]   = r_exc_code;
  end

  always_comb begin
    RdData = '0;
    case (RdAddr)
      REG_BADVADDR: RdData = w_badvaddr;
      REG_SR:       RdData = w_sr;
      REG_CAUSE:    RdData = w_cause;
      REG_EPC:      RdData = r_epc;
      REG_PRID:     RdData = PRID;
      default:      RdData = '0;
    endcase
  end

  assign Req      = w_req;
  assign ExcEntry = EXC_ENTRY;
  assign EPCOut   = r_epc;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed self-checking bench for cp0_irq_ctrl.
module tb_cp0_irq_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [4:0]  RdAddr, WrAddr, ExcCodeIn;
  logic [31:0] WrData, VPC, VAddr;
  logic        WE, BDIn, EXLClr;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] ExcEntry, EPCOut, RdData;

  int n_chk  = 0;
  int n_fail = 0;

  cp0_irq_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .RdAddr(RdAddr), .WrAddr(WrAddr),
    .WrData(WrData), .WE(WE), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .VAddr(VAddr), .HWInt(HWInt), .EXLClr(EXLClr), .Req(Req),
    .ExcEntry(ExcEntry), .EPCOut(EPCOut), .RdData(RdData)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    RdAddr = a;
    #1;
    chk(tag, RdData, exp);
  endtask

  initial begin
    RST_I = 1'b1; RdAddr = '0; WrAddr = '0; WrData = '0; WE = 1'b0;
    VPC = '0; BDIn = 1'b0; ExcCodeIn = '0; VAddr = '0; HWInt = '0; EXLClr = 1'b0;
    step(); step();
    RST_I = 1'b0;

    // 1: reset state
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("prid", 5'd15, 32'h0000_5200);
    chk("rst_epcout", EPCOut, 32'h0);
    chk("exc_entry", ExcEntry, 32'h0000_4180);
    HWInt = 6'h3f; #1;
    chk("rst_req_masked", {31'b0, Req}, 32'h0);
    HWInt = 6'h0;

    // 2: mtc0 SR (upper garbage dropped), then timer 0 interrupt
    WE = 1'b1; WrAddr = 5'd12; WrData = 32'hFFFF_0401;
    step();
    WE = 1'b0;
    rd("sr_write", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; VPC = 32'h0000_3010; BDIn = 1'b0; #1;
    chk("int_req", {31'b0, Req}, 32'h1);
    step();
    rd("int_epc", 5'd14, 32'h0000_3010);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_cause", 5'd13, 32'h0000_0400);
    chk("int_epcout", EPCOut, 32'h0000_3010);

    // 3: EXL masks everything; eret reopens
    ExcCodeIn = 5'd12; #1;
    chk("exl_mask", {31'b0, Req}, 32'h0);
    step();
    ExcCodeIn = 5'd0; EXLClr = 1'b1; #1;
    chk("eret_cycle_req", {31'b0, Req}, 32'h0);
    step();
    EXLClr = 1'b0; #1;
    chk("req_reassert", {31'b0, Req}, 32'h1);
    rd("eret_sr", 5'd12, 32'h0000_0401);

    // interrupt beats a simultaneous exception
    ExcCodeIn = 5'd12; VPC = 32'h0000_3040; #1;
    step();
    rd("prio_cause", 5'd13, 32'h0000_0400);
    rd("prio_epc", 5'd14, 32'h0000_3040);
    ExcCodeIn = 5'd0; HWInt = 6'h0; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;

    // 4: RI in a delay slot
    WE = 1'b1; WrAddr = 5'd12; WrData = 32'h0000_0001;
    step();
    WE = 1'b0;
    ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h0000_3020; #1;
    chk("ri_req", {31'b0, Req}, 32'h1);
    step();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd("ri_epc", 5'd14, 32'h0000_301C);
    rd("ri_cause", 5'd13, 32'h8000_0028);
    rd("ri_sr", 5'd12, 32'h0000_0003);

    // SR write sets EXL, same-cycle eret still clears it
    WE = 1'b1; WrAddr = 5'd12; WrData = 32'h0000_0403; EXLClr = 1'b1;
    step();
    WE = 1'b0; EXLClr = 1'b0;
    rd("mtc0_eret_sr", 5'd12, 32'h0000_0401);

    // 5: EPC write alignment, and write discarded under Req
    WE = 1'b1; WrAddr = 5'd14; WrData = 32'h0000_3007;
    step();
    rd("epc_align", 5'd14, 32'h0000_3004);
    ExcCodeIn = 5'd12; VPC = 32'h0000_3050; #1;
    chk("ov_req", {31'b0, Req}, 32'h1);
    step();
    WE = 1'b0; ExcCodeIn = 5'd0;
    rd("epc_flushed_wr", 5'd14, 32'h0000_3050);
    rd("ov_cause", 5'd13, 32'h0000_0030);

    // 6: AdEL / BadVAddr
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    ExcCodeIn = 5'd4; VAddr = 32'h0000_0003; VPC = 32'h0000_3060;
    step();
    ExcCodeIn = 5'd0; VAddr = 32'h0;
`ifdef CP0_BADVADDR_EN
    rd("badvaddr", 5'd8, 32'h0000_0003);
`else
    rd("badvaddr", 5'd8, 32'h0);
`endif
    rd("other_reg", 5'd20, 32'h0);

    // Cause is read-only to mtc0
    WE = 1'b1; WrAddr = 5'd13; WrData = 32'hFFFF_FFFF;
    step();
    WE = 1'b0;
    rd("cause_ro", 5'd13, 32'h0000_0010);

    // reset mid-handler
    RST_I = 1'b1;
    step();
    RST_I = 1'b0;
    rd("midrst_sr", 5'd12, 32'h0);
    rd("midrst_epc", 5'd14, 32'h0);
    chk("midrst_epcout", EPCOut, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
- Coprocessor-0 block inside the CPU that receives and acts on interrupts raised by bus devices (timers and others, via each device's `IRQ` line).
- Holds SR, Cause, EPC and PRId.
- Raises a single exception/interrupt request to the pipeline and captures the victim PC.
- Services `mfc0`/`mtc0` from the M stage and `eret`.

Parameters:
- PRID, 32'h0000_5200, constant read value of PRId (reg 15).
- EXC_ENTRY, 32'h0000_4180, handler address driven on `ExcEntry`.

Ports:
- CLK_I  in  1  system clock; all state updates on rising edge.
- RST_I  in  1  synchronous reset, active-high.
- RdAddr  in  5  CP0 register number for `mfc0` read.
- WrAddr  in  5  CP0 register number for `mtc0` write.
- WrData  in  32  `mtc0` data.
- WE  in  1  `mtc0` write enable.
- VPC  in  32  PC of the instruction in M stage (victim).
- BDIn  in  1  victim is in a branch delay slot.
- ExcCodeIn  in  5  synchronous exception code from pipeline; 0 = none.
- VAddr  in  32  faulting data address (used only with the optional feature).
- HWInt  in  6  device interrupt lines; bit 0 = timer 0, bit 1 = timer 1, bit 2 = external.
- EXLClr  in  1  `eret` in M stage.
- Req  out  1  take exception/interrupt this cycle (flush pipeline).
- ExcEntry  out  32  handler PC (= EXC_ENTRY).
- EPCOut  out  32  current EPC, for `eret`.
- RdData  out  32  read data for RdAddr.

Behaviour:
Reset:
- SR = 0, Cause = 0, EPC = 0.
- Outputs after reset: `Req` = 0, `RdData` = 0 for regs 12/13/14, `EPCOut` = 0.

Register layout:
- SR (reg 12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0 and ignore writes.
- Cause (reg 13): BD = [31], IP = [15:10], ExcCode = [6:2]; read-only to `mtc0`.
- EPC (reg 14): read/write; writes stored with [1:0] forced to 0.
- PRId (reg 15): returns PRID.
- Any other register number: reads 0, writes ignored.

Request logic (combinational, same cycle as inputs):
- IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
- ExcReq = (ExcCodeIn != 0) & !SR.EXL.
- `Req` = IntReq | ExcReq.

Cause.IP:
- Loaded from `HWInt` every cycle (level view, one cycle delayed), regardless of IM/IE/EXL.

On a clock edge with `Req` = 1:
- EXL <= 1.
- BD <= BDIn.
- EPC <= (BDIn ? VPC-4 : VPC) with [1:0] cleared.
- ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.

`eret`:
- `EXLClr` = 1 and `Req` = 0: EXL <= 0 at the edge.
- `EXLClr` and `Req` in the same cycle: `Req` wins.

`mtc0`:
- Applied only when `WE` = 1 and `Req` = 0. A write in a `Req` cycle is discarded, because the instruction was flushed.
- `mtc0` to SR and `EXLClr` in the same cycle: the SR write applies first, then EXL is cleared.

Read timing:
- `RdData` is combinational from current register state; a write is visible the cycle after.

Nesting and reset:
- EXL = 1 masks all requests, including exceptions. No nesting.
- `RST_I` asserted mid-handler clears EXL/EPC immediately at the edge.

Optional Feature:
- Macro `CP0_BADVADDR_EN`.
- Defined: adds BadVAddr (reg 8), read-only. Captures `VAddr` on a `Req` edge when ExcCodeIn is 4 (AdEL) or 5 (AdES) and IntReq = 0. Resets to 0.
- Undefined: reg 8 reads 0 and `VAddr` is ignored; the port remains for a stable interface.

Decomposition:
- Shared package `cp0_pkg` holds:
  - Register numbers SR/CAUSE/EPC/PRID/BADVADDR.
  - Bit-field positions for IM, EXL, IE, BD, IP, ExcCode.
  - Exception codes: Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12.
- One natural sub-module: `cp0_req_arb`, the combinational IntReq/ExcReq priority and ExcCode select. Register file logic stays in the top module.

Test Plan:
1. Reset, then read regs 12/13/14 -> all 0; read reg 15 -> 32'h0000_5200; `Req` = 0 with any `HWInt`.
2. `mtc0` SR = 32'h0000_0401 (IM0, IE), then HWInt = 6'b000001 with VPC = 32'h0000_3010, BDIn = 0:
   - `Req` = 1 in the same cycle.
   - Next cycle EPC = 32'h0000_3010, SR = 32'h0000_0403, Cause.ExcCode = 0, Cause.IP = 6'b000001.
3. Inside the handler (EXL = 1), HWInt = 6'b000001 and ExcCodeIn = 12 -> `Req` = 0. Then `EXLClr` for one cycle -> EXL = 0 and `Req` reasserts the same cycle the still-high `HWInt` is seen.
4. SR = 32'h0000_0001, ExcCodeIn = 10, BDIn = 1, VPC = 32'h0000_3020 -> `Req` = 1; next cycle EPC = 32'h0000_301C, BD = 1, ExcCode = 10.
5. `mtc0` EPC = 32'h0000_3007 with `Req` = 0 -> EPC reads 32'h0000_3004. The same write in a cycle with `Req` = 1 -> EPC holds the captured PC instead.
6. With `CP0_BADVADDR_EN`, ExcCodeIn = 4, VAddr = 32'h0000_0003 -> reg 8 reads 32'h0000_0003. Without the macro, reg 8 reads 0.
